obc1_oam_arb: RTL and testbench

- Arbiter and sequencer for the single-ported OBC1 OAM/register RAM path.
- Shares the RAM between the SNES bus and the MCU debug/savestate port.
- SNES accesses always win and pre-empt; MCU accesses run in the gaps under a 4-phase req/ack handshake.
- A starvation watchdog flags an MCU port held off too long.
- Sits between the SNES address decoder / MCU command interface and the OBC1 core's RAM-facing signals.

---
 rtl/obc1_oam_arb.sv | 167 ++++++++++++++++
 tb/tb_obc1_oam_arb.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obc1_oam_arb.sv
// OBC1 OAM/register RAM arbiter: SNES accesses pre-empt, MCU accesses run in the
// gaps under a 4-phase req/ack handshake, with a starvation watchdog on the MCU port.
module obc1_oam_arb #(
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned SNES_HOLD   = 4,
  parameter int unsigned MCU_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              snes_enable,
  input  logic [ADDR_W-1:0] snes_addr,
  input  logic [7:0]        snes_data_in,
  input  logic              snes_rd_strobe,
  input  logic              snes_wr_strobe,
  input  logic              mcu_req,
  input  logic              mcu_we,
  input  logic [ADDR_W-1:0] mcu_addr,
  input  logic [7:0]        mcu_wdata,
  output logic [7:0]        mcu_rdata,
  output logic              mcu_ack,
  output logic              mcu_starved,
  input  logic              mcu_starved_clr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we_n,
  output logic              ram_oe_n,
  input  logic [7:0]        ram_rdata,
  output logic              snes_owner
);

  localparam int unsigned HOLD_W = (SNES_HOLD > 1) ? $clog2(SNES_HOLD) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNES_HOLD,
    ST_MCU_ISSUE,
    ST_MCU_READ,
    ST_MCU_ACK
  } state_e;

  state_e              state_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [7:0]          wait_q, wait_d;
  logic                armed_q;
  logic                op_we_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [7:0]          ram_data_q;
  logic                ram_we_n_q, ram_oe_n_q;
  logic [7:0]          mcu_rdata_q;
  logic                mcu_ack_q, mcu_starved_q, snes_owner_q;

  logic snes_go, mcu_busy, grant, wait_inc, starve_set;

  assign snes_go  = (snes_rd_strobe | snes_wr_strobe) & snes_enable;
  assign mcu_busy = (state_q == ST_MCU_ISSUE) || (state_q == ST_MCU_READ) ||
                    (state_q == ST_MCU_ACK);
  assign grant    = (state_q == ST_IDLE) && !snes_go && mcu_req && armed_q;
  assign wait_inc = mcu_req && armed_q && !mcu_busy;

  // The grant cycle itself never counts as waiting: entry to issue clears.
  always_comb begin
    wait_d = wait_q;
    if (grant) begin
      wait_d = '0;
    end else if (wait_inc && (wait_q != 8'hFF)) begin
      wait_d = wait_q + 8'd1;
    end
  end

  assign starve_set = wait_inc && !grant && (wait_q == 8'(MCU_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      hold_q        <= '0;
      wait_q        <= '0;
      armed_q       <= 1'b1;
      op_we_q       <= 1'b0;
      ram_addr_q    <= '0;
      ram_data_q    <= '0;
      ram_we_n_q    <= 1'b1;
      ram_oe_n_q    <= 1'b1;
      mcu_rdata_q   <= '0;
      mcu_ack_q     <= 1'b0;
      mcu_starved_q <= 1'b0;
      snes_owner_q  <= 1'b0;
    end else begin
      // Ack fires from MCU_ACK even when a SNES strobe pre-empts that cycle.
      mcu_ack_q <= (state_q == ST_MCU_ACK);
      wait_q    <= wait_d;

      if (state_q == ST_MCU_ACK) begin
        armed_q <= 1'b0;
      end else if (!mcu_req) begin
        armed_q <= 1'b1;
      end

      if (starve_set) begin
        mcu_starved_q <= 1'b1;
      end else if (mcu_starved_clr) begin
        mcu_starved_q <= 1'b0;
      end

      if (snes_go) begin
        state_q      <= ST_SNES_HOLD;
        hold_q       <= HOLD_W'(SNES_HOLD - 1);
        snes_owner_q <= 1'b1;
        ram_addr_q   <= snes_addr;
        ram_data_q   <= snes_data_in;
        ram_we_n_q   <= ~snes_wr_strobe;
        ram_oe_n_q   <= snes_wr_strobe;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (grant) begin
              state_q    <= ST_MCU_ISSUE;
              op_we_q    <= mcu_we;
              ram_addr_q <= mcu_addr;
              ram_data_q <= mcu_wdata;
              ram_we_n_q <= ~mcu_we;
              ram_oe_n_q <= mcu_we;
            end
          end
          ST_SNES_HOLD: begin
            ram_we_n_q <= 1'b1;
            if (hold_q == '0) begin
              state_q      <= ST_IDLE;
              snes_owner_q <= 1'b0;
              ram_oe_n_q   <= 1'b1;
            end else begin
              hold_q <= hold_q - 1'b1;
            end
          end
          ST_MCU_ISSUE: begin
            if (op_we_q) begin
              state_q    <= ST_MCU_ACK;
              ram_we_n_q <= 1'b1;
            end else begin
              state_q <= ST_MCU_READ;
            end
          end
          ST_MCU_READ: begin
            mcu_rdata_q <= ram_rdata;
            ram_oe_n_q  <= 1'b1;
            state_q     <= ST_MCU_ACK;
          end
          ST_MCU_ACK: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign ram_addr    = ram_addr_q;
  assign ram_data    = ram_data_q;
  assign ram_we_n    = ram_we_n_q;
  assign ram_oe_n    = ram_oe_n_q;
  assign mcu_rdata   = mcu_rdata_q;
  assign mcu_ack     = mcu_ack_q;
  assign mcu_starved = mcu_starved_q;
  assign snes_owner  = snes_owner_q;

endmodule

// File: tb/tb_obc1_oam_arb.sv
// Bench for obc1_oam_arb: vector table, directed corner sequences and a random
// phase, all cross-checked each cycle against a transaction-level reference model.
module tb_obc1_oam_arb;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned HOLD   = 4;
  localparam int unsigned TMO    = 255;
  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              snes_enable, snes_rd_strobe, snes_wr_strobe;
  logic [ADDR_W-1:0] snes_addr, mcu_addr;
  logic [7:0]        snes_data_in, mcu_wdata;
  logic              mcu_req, mcu_we, mcu_starved_clr;
  logic [7:0]        mcu_rdata, ram_data, ram_rdata;
  logic              mcu_ack, mcu_starved, ram_we_n, ram_oe_n, snes_owner;
  logic [ADDR_W-1:0] ram_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  obc1_oam_arb #(.ADDR_W(ADDR_W), .SNES_HOLD(HOLD), .MCU_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .snes_enable(snes_enable), .snes_addr(snes_addr), .snes_data_in(snes_data_in),
    .snes_rd_strobe(snes_rd_strobe), .snes_wr_strobe(snes_wr_strobe),
    .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_addr(mcu_addr), .mcu_wdata(mcu_wdata),
    .mcu_rdata(mcu_rdata), .mcu_ack(mcu_ack), .mcu_starved(mcu_starved),
    .mcu_starved_clr(mcu_starved_clr),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n),
    .ram_rdata(ram_rdata), .snes_owner(snes_owner)
  );

  // RAM with one-cycle registered read.
  logic [7:0] mem    [0:(1<<ADDR_W)-1];
  logic [7:0] shadow [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (!ram_oe_n) ram_rdata <= mem[ram_addr];
    if (!ram_we_n) mem[ram_addr] = ram_data;
  end

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks a hold countdown and an in-flight MCU op by age.
  int                hold_left, op_age, waitc;
  bit                op_act, op_we, armed;
  logic [ADDR_W-1:0] op_addr, e_addr;
  logic [7:0]        e_data, e_rdata;
  bit                e_we_n, e_oe_n, e_ack, e_starved, e_owner;
  bit                m_strobe, m_ackph, m_grant, m_inc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_left = -1; op_act = 0; op_age = 0; op_we = 0; armed = 1; waitc = 0;
      e_addr = '0; e_data = '0; e_rdata = '0; e_we_n = 1; e_oe_n = 1;
      e_ack = 0; e_starved = 0; e_owner = 0; op_addr = '0;
    end else begin
      m_strobe = (snes_rd_strobe | snes_wr_strobe) & snes_enable;
      m_ackph  = op_act && (op_age == (op_we ? 1 : 2));
      m_grant  = !m_strobe && hold_left < 0 && !op_act && mcu_req && armed;
      m_inc    = mcu_req && armed && !op_act;
      e_ack = m_ackph;
      if (m_inc && !m_grant && waitc == int'(TMO) - 1) e_starved = 1;
      else if (mcu_starved_clr) e_starved = 0;
      if (m_grant) waitc = 0;
      else if (m_inc && waitc < 255) waitc++;
      if (m_ackph) armed = 0;
      else if (!mcu_req) armed = 1;
      if (m_strobe) begin
        e_owner = 1; e_addr = snes_addr; e_data = snes_data_in;
        e_we_n = !snes_wr_strobe; e_oe_n = snes_wr_strobe;
        if (snes_wr_strobe) shadow[snes_addr] = snes_data_in;
        hold_left = int'(HOLD) - 1; op_act = 0;
      end else if (hold_left >= 0) begin
        e_we_n = 1;
        if (hold_left == 0) begin hold_left = -1; e_owner = 0; e_oe_n = 1; end
        else hold_left--;
      end else if (op_act) begin
        if (m_ackph) op_act = 0;
        else if (op_age == 0) begin if (op_we) e_we_n = 1; op_age = 1; end
        else begin e_rdata = shadow[op_addr]; e_oe_n = 1; op_age = 2; end
      end else if (m_grant) begin
        op_act = 1; op_age = 0; op_we = mcu_we; op_addr = mcu_addr;
        e_addr = mcu_addr; e_data = mcu_wdata; e_we_n = !mcu_we; e_oe_n = mcu_we;
        if (mcu_we) shadow[mcu_addr] = mcu_wdata;
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      cmp("m_ram_addr", 16'(ram_addr), 16'(e_addr));
      cmp("m_ram_data", 16'(ram_data), 16'(e_data));
      cmp("m_ram_we_n", 16'(ram_we_n), 16'(e_we_n));
      cmp("m_ram_oe_n", 16'(ram_oe_n), 16'(e_oe_n));
      cmp("m_mcu_rdata", 16'(mcu_rdata), 16'(e_rdata));
      cmp("m_mcu_ack", 16'(mcu_ack), 16'(e_ack));
      cmp("m_mcu_starved", 16'(mcu_starved), 16'(e_starved));
      cmp("m_snes_owner", 16'(snes_owner), 16'(e_owner));
    end
  end

  typedef struct {
    logic en, rd, wr; logic [12:0] sa;
    logic req, we; logic [12:0] ma; logic [7:0] wd;
    logic [12:0] xa; logic xwe, xoe, xack, xown; logic [7:0] xrd;
  } vec_t;

  function automatic vec_t mk(input logic en, rd, wr, input logic [12:0] sa,
                              input logic req, we, input logic [12:0] ma, input logic [7:0] wd,
                              input logic [12:0] xa, input logic xwe, xoe, xack, xown,
                              input logic [7:0] xrd);
    vec_t v;
    v.en = en; v.rd = rd; v.wr = wr; v.sa = sa; v.req = req; v.we = we; v.ma = ma; v.wd = wd;
    v.xa = xa; v.xwe = xwe; v.xoe = xoe; v.xack = xack; v.xown = xown; v.xrd = xrd;
    return v;
  endfunction

  task automatic mcu_op(input logic we, input logic [12:0] a, input logic [7:0] wd,
                        output int lat, output logic [7:0] rd);
    mcu_req = 1; mcu_we = we; mcu_addr = a; mcu_wdata = wd; lat = 0;
    while (lat < 50) begin
      @(negedge clk); lat++;
      if (mcu_ack) break;
    end
    rd = mcu_rdata;
    mcu_req = 0;
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench did not finish");
  end

  vec_t       tbl[16];
  int         lat, n, own, acks, wen, st, gap;
  logic [7:0] rd;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin mem[i] = 8'h00; shadow[i] = 8'h00; end
    snes_enable = 0; snes_rd_strobe = 0; snes_wr_strobe = 0; snes_addr = '0; snes_data_in = '0;
    mcu_req = 0; mcu_we = 0; mcu_addr = '0; mcu_wdata = '0; mcu_starved_clr = 0;

    tbl[0]  = mk(O,O,O,13'h0000, I,I,13'h1804,8'h5A, 13'h1804,O,I,O,O,8'h00);
    tbl[1]  = mk(O,O,O,13'h0000, I,I,13'h1804,8'h5A, 13'h1804,I,I,O,O,8'h00);
    tbl[2]  = mk(O,O,O,13'h0000, I,I,13'h1804,8'h5A, 13'h1804,I,I,I,O,8'h00);
    tbl[3]  = mk(O,O,O,13'h0000, O,O,13'h1804,8'h00, 13'h1804,I,I,O,O,8'h00);
    tbl[4]  = mk(O,O,O,13'h0000, I,O,13'h1804,8'h00, 13'h1804,I,O,O,O,8'h00);
    tbl[5]  = mk(O,O,O,13'h0000, I,O,13'h1804,8'h00, 13'h1804,I,O,O,O,8'h00);
    tbl[6]  = mk(O,O,O,13'h0000, I,O,13'h1804,8'h00, 13'h1804,I,I,O,O,8'h5A);
    tbl[7]  = mk(O,O,O,13'h0000, I,O,13'h1804,8'h00, 13'h1804,I,I,I,O,8'h5A);
    tbl[8]  = mk(O,O,O,13'h0000, O,O,13'h1804,8'h00, 13'h1804,I,I,O,O,8'h5A);
    tbl[9]  = mk(O,I,O,13'h0234, O,O,13'h1804,8'h00, 13'h1804,I,I,O,O,8'h5A);
    tbl[10] = mk(O,O,I,13'h0235, O,O,13'h1804,8'h00, 13'h1804,I,I,O,O,8'h5A);
    tbl[11] = mk(I,I,O,13'h1100, O,O,13'h1804,8'h00, 13'h1100,I,O,O,I,8'h5A);
    tbl[12] = mk(O,O,O,13'h0000, O,O,13'h1804,8'h00, 13'h1100,I,O,O,I,8'h5A);
    tbl[13] = mk(O,O,O,13'h0000, O,O,13'h1804,8'h00, 13'h1100,I,O,O,I,8'h5A);
    tbl[14] = mk(O,O,O,13'h0000, O,O,13'h1804,8'h00, 13'h1100,I,O,O,I,8'h5A);
    tbl[15] = mk(O,O,O,13'h0000, O,O,13'h1804,8'h00, 13'h1100,I,I,O,O,8'h5A);

    repeat (3) @(negedge clk);
    cmp("rst_ram_addr", 16'(ram_addr), 16'h0);
    cmp("rst_ram_data", 16'(ram_data), 16'h0);
    cmp("rst_ram_we_n", 16'(ram_we_n), 16'h1);
    cmp("rst_ram_oe_n", 16'(ram_oe_n), 16'h1);
    cmp("rst_mcu_rdata", 16'(mcu_rdata), 16'h0);
    cmp("rst_mcu_ack", 16'(mcu_ack), 16'h0);
    cmp("rst_mcu_starved", 16'(mcu_starved), 16'h0);
    cmp("rst_snes_owner", 16'(snes_owner), 16'h0);
    rst_n = 1; chk_en = 1;

    // Uncontended write/read of 0x1804, then a disabled and an enabled SNES read.
    for (int i = 0; i < 16; i++) begin
      snes_enable = tbl[i].en; snes_rd_strobe = tbl[i].rd; snes_wr_strobe = tbl[i].wr;
      snes_addr = tbl[i].sa; mcu_req = tbl[i].req; mcu_we = tbl[i].we;
      mcu_addr = tbl[i].ma; mcu_wdata = tbl[i].wd;
      @(negedge clk);
      cmp("tbl_ram_addr", 16'(ram_addr), 16'(tbl[i].xa));
      cmp("tbl_ram_we_n", 16'(ram_we_n), 16'(tbl[i].xwe));
      cmp("tbl_ram_oe_n", 16'(ram_oe_n), 16'(tbl[i].xoe));
      cmp("tbl_mcu_ack", 16'(mcu_ack), 16'(tbl[i].xack));
      cmp("tbl_snes_owner", 16'(snes_owner), 16'(tbl[i].xown));
      cmp("tbl_mcu_rdata", 16'(mcu_rdata), 16'(tbl[i].xrd));
    end
    snes_enable = 0; snes_rd_strobe = 0; snes_wr_strobe = 0;

    // SNES write pre-empts an MCU read in MCU_READ.
    mcu_op(1, 13'h1A10, 8'h3C, lat, rd);
    cmp("pre_wr_lat", 16'(lat), 16'd3);
    mcu_req = 1; mcu_we = 0; mcu_addr = 13'h1A10;
    @(negedge clk); @(negedge clk);
    snes_enable = 1; snes_wr_strobe = 1; snes_addr = 13'h1FF6; snes_data_in = 8'h12;
    @(negedge clk);
    snes_wr_strobe = 0; snes_enable = 0;
    cmp("pre_we_n", 16'(ram_we_n), 16'h0);
    cmp("pre_addr", 16'(ram_addr), 16'h1FF6);
    cmp("pre_data", 16'(ram_data), 16'h12);
    own = 1; acks = 0; n = 0;
    while (snes_owner && n < 20) begin
      @(negedge clk); n++;
      if (mcu_ack) acks++;
      if (snes_owner) own++;
    end
    cmp("pre_owner_cycles", 16'(own), 16'd4);
    cmp("pre_no_ack_in_hold", 16'(acks), 16'd0);
    n = 0;
    while (n < 30) begin @(negedge clk); n++; if (mcu_ack) break; end
    cmp("pre_reissue_lat", 16'(n), 16'd4);
    cmp("pre_reissue_data", 16'(mcu_rdata), 16'h3C);
    mcu_req = 0; @(negedge clk);

    // SNES reads every 3 cycles starve the MCU.
    mcu_req = 1; mcu_we = 0; mcu_addr = 13'h0040; st = 0; acks = 0;
    for (int c = 1; c <= 300; c++) begin
      snes_enable = 1; snes_rd_strobe = (c % 3 == 1); snes_addr = 13'h0100;
      @(negedge clk);
      if (mcu_ack) acks++;
      if (mcu_starved && st == 0) st = c;
    end
    snes_rd_strobe = 0; snes_enable = 0;
    cmp("starve_at_cycle", 16'(st), 16'd255);
    cmp("starve_no_grant", 16'(acks), 16'd0);
    n = 0;
    while (n < 50) begin @(negedge clk); n++; if (mcu_ack) break; end
    cmp("starve_release_lat", 16'(n), 16'd6);
    cmp("starve_sticky", 16'(mcu_starved), 16'h1);
    mcu_req = 0; mcu_starved_clr = 1;
    @(negedge clk);
    mcu_starved_clr = 0;
    cmp("starve_cleared", 16'(mcu_starved), 16'h0);

    // Held request after ack yields one op; a one-cycle drop re-arms.
    mcu_req = 1; mcu_we = 1; mcu_addr = 13'h0050; mcu_wdata = 8'h77;
    n = 0; acks = 0; wen = 0;
    while (acks == 0 && n < 50) begin
      @(negedge clk); n++;
      if (mcu_ack) acks++;
      if (!ram_we_n) wen++;
    end
    repeat (20) begin
      @(negedge clk);
      if (mcu_ack) acks++;
      if (!ram_we_n) wen++;
    end
    cmp("hs_single_op", 16'(acks), 16'd1);
    cmp("hs_single_we", 16'(wen), 16'd1);
    mcu_req = 0; @(negedge clk);
    mcu_req = 1; mcu_we = 0; n = 0;
    while (n < 50) begin @(negedge clk); n++; if (mcu_ack) break; end
    cmp("hs_second_lat", 16'(n), 16'd4);
    cmp("hs_second_data", 16'(mcu_rdata), 16'h77);
    mcu_req = 0; @(negedge clk);

    // Reset asserted while an MCU read is in flight.
    mcu_req = 1; mcu_we = 0; mcu_addr = 13'h0050;
    @(negedge clk);
    @(posedge clk); #2; rst_n = 0; #1;
    cmp("rstmid_oe_n", 16'(ram_oe_n), 16'h1);
    cmp("rstmid_addr", 16'(ram_addr), 16'h0);
    cmp("rstmid_rdata", 16'(mcu_rdata), 16'h0);
    cmp("rstmid_ack", 16'(mcu_ack), 16'h0);
    mcu_req = 0; acks = 0;
    repeat (3) begin @(negedge clk); if (mcu_ack) acks++; end
    rst_n = 1;
    repeat (3) begin @(negedge clk); if (mcu_ack) acks++; end
    cmp("rstmid_no_ack", 16'(acks), 16'd0);
    mcu_op(0, 13'h0050, 8'h00, lat, rd);
    cmp("rstmid_after_lat", 16'(lat), 16'd4);
    cmp("rstmid_after_data", 16'(rd), 16'h77);

    // Random traffic on a small address range so both sides collide.
    gap = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        snes_enable = ($urandom_range(0, 4) != 0);
        snes_rd_strobe = 1'($urandom); snes_wr_strobe = 1'($urandom);
        if (!snes_rd_strobe && !snes_wr_strobe) snes_rd_strobe = 1;
        snes_addr = 13'($urandom_range(0, 15)); snes_data_in = 8'($urandom);
      end else begin
        snes_rd_strobe = 0; snes_wr_strobe = 0;
      end
      mcu_starved_clr = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      if (mcu_req && mcu_ack) begin
        mcu_req = 0; gap = $urandom_range(0, 5);
      end else if (!mcu_req) begin
        if (gap == 0) begin
          mcu_req = 1; mcu_we = 1'($urandom);
          mcu_addr = 13'($urandom_range(0, 15)); mcu_wdata = 8'($urandom);
        end else begin
          gap--;
        end
      end
    end
    snes_rd_strobe = 0; snes_wr_strobe = 0; mcu_starved_clr = 0;
    repeat (2) @(negedge clk);
    chk_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
